frame_update_sequencer: RTL and testbench

- Schedules once-per-frame game-state updates (bird physics, pipe scroll, collision, score) so they run only during vertical blanking.
- Watches the scan-line count from the VGA timing block and detects entry into blanking.
- Issues a one-hot req/ack handshake to each update engine in fixed order, guarded by a per-phase timeout.
- Reports frame count, completion, and sticky error flags to the top-level game FSM.

---
 rtl/frame_update_sequencer.sv | 161 ++++++++++++++++
 tb/tb_frame_update_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_sequencer.sv
// Runs the per-frame game-state update engines in fixed order during vertical blanking,
// using a one-hot req/ack handshake with a per-phase timeout and sticky error reporting.
module frame_update_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int VD         = 480,
    parameter int TIMEOUT    = 4096,
    parameter int FRAME_DIV  = 1,
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1,
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [9:0]            y,
    input  logic [NUM_PHASES-1:0] upd_ack,
    input  logic                  clr_err,
    output logic [NUM_PHASES-1:0] upd_req,
    output logic [PW-1:0]         phase_idx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  timeout_err,
    output logic [PW-1:0]         err_phase,
    output logic                  overrun,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [9:0] C_VD = 10'(VD);

    state_t                r_state;
    logic [9:0]            r_y_prev;
    logic [TW-1:0]         r_timer;
    logic [DW-1:0]         r_div_cnt;
    logic [NUM_PHASES-1:0] r_upd_req;
    logic [PW-1:0]         r_phase_idx;
    logic                  r_frame_done;
    logic [15:0]           r_frame_cnt;
    logic                  r_timeout_err;
    logic [PW-1:0]         r_err_phase;
    logic                  r_overrun;

    logic                  w_blank_start;
    logic                  w_disp_start;
    logic                  w_trigger;
    logic                  w_ack;
    logic                  w_expire;
    logic                  w_last;
    logic                  w_advance;
    logic                  w_to_set;
    logic                  w_ovr_set;
    logic [NUM_PHASES-1:0] w_next_req;

    assign w_blank_start = (y == C_VD) && (r_y_prev != C_VD);
    assign w_disp_start  = (y == 10'd0) && (r_y_prev != 10'd0);
    assign w_trigger     = w_blank_start && (r_div_cnt == '0) && enable && (r_state == S_IDLE);

    // Only the active phase's ack bit counts; an ack coinciding with expiry is a clean ack.
    assign w_ack      = upd_ack[r_phase_idx];
    assign w_expire   = (r_timer == TW'(TIMEOUT - 1));
    assign w_last     = (r_phase_idx == PW'(NUM_PHASES - 1));
    assign w_advance  = (r_state == S_REQ) && (w_ack || w_expire);
    assign w_to_set   = (r_state == S_REQ) && !w_ack && w_expire;
    assign w_ovr_set  = (r_state != S_IDLE) && (w_blank_start || w_disp_start);
    assign w_next_req = NUM_PHASES'(1) << (r_phase_idx + PW'(1));

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_y_prev      <= '0;
            r_timer       <= '0;
            r_div_cnt     <= '0;
            r_upd_req     <= '0;
            r_phase_idx   <= '0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
            r_err_phase   <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_y_prev     <= y;
            r_frame_done <= 1'b0;

            if (w_blank_start) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_div_cnt   <= (r_div_cnt == DW'(FRAME_DIV - 1)) ? '0 : r_div_cnt + DW'(1);
            end

            // Set events take priority over a simultaneous clear.
            if (w_to_set) begin
                r_timeout_err <= 1'b1;
                r_err_phase   <= r_phase_idx;
            end else if (clr_err) begin
                r_timeout_err <= 1'b0;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_upd_req <= '0;
                    if (w_trigger) begin
                        r_state     <= S_REQ;
                        r_phase_idx <= '0;
                        r_timer     <= '0;
                        r_upd_req   <= NUM_PHASES'(1);
                    end
                end
                S_REQ: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_advance) begin
                        r_upd_req <= '0;
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // One idle request cycle guarantees every request has a rising edge.
                    r_phase_idx <= r_phase_idx + PW'(1);
                    r_timer     <= '0;
                    r_upd_req   <= w_next_req;
                    r_state     <= S_REQ;
                end
                S_DONE: begin
                    r_upd_req <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_upd_req <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign upd_req     = r_upd_req;
    assign phase_idx   = r_phase_idx;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;
    assign err_phase   = r_err_phase;
    assign overrun     = r_overrun;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Bench for frame_update_sequencer: one instance with FRAME_DIV=1 and one with FRAME_DIV=3,
// both with a short timeout, driven by behavioural update engines and a request scoreboard.
module tb_frame_update_sequencer;

  logic       clk_100MHz;
  logic       reset_n;
  logic       enable;
  logic [9:0] y;
  logic       clr_err;

  logic [3:0]  ack_a, resp_a, spur_a, req_a;
  logic [1:0]  phase_a, err_phase_a, dbg_a;
  logic        busy_a, done_a, timeout_a, overrun_a;
  logic [15:0] fcnt_a;

  logic [3:0]  ack_b, req_b;
  logic [1:0]  phase_b, err_phase_b, dbg_b;
  logic        busy_b, done_b, timeout_b, overrun_b;
  logic [15:0] fcnt_b;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_q[$];
  int exp_fc = 0;

  // request-side observations
  logic [3:0] prev_a = '0;
  int cur_len = 0;
  int zero_run = 0;
  int hi_len[4];
  int done_cnt_a = 0;
  logic [3:0] prev_b = '0;
  int seq_b = 0;
  int done_cnt_b = 0;

  // engine model knobs
  int cnt_a = 0;
  int cnt_b = 0;
  int stall_phase = -1;
  int slow_phase = -1;
  int slow_delay = 3;

  assign ack_a = resp_a | spur_a;

  frame_update_sequencer #(.NUM_PHASES(4), .VD(480), .TIMEOUT(16), .FRAME_DIV(1)) u_a (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .y(y),
    .upd_ack(ack_a), .clr_err(clr_err), .upd_req(req_a), .phase_idx(phase_a),
    .busy(busy_a), .frame_done(done_a), .frame_cnt(fcnt_a), .timeout_err(timeout_a),
    .err_phase(err_phase_a), .overrun(overrun_a), .dbg_state(dbg_a)
  );

  frame_update_sequencer #(.NUM_PHASES(4), .VD(480), .TIMEOUT(16), .FRAME_DIV(3)) u_b (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .y(y),
    .upd_ack(ack_b), .clr_err(clr_err), .upd_req(req_b), .phase_idx(phase_b),
    .busy(busy_b), .frame_done(done_b), .frame_cnt(fcnt_b), .timeout_err(timeout_b),
    .err_phase(err_phase_b), .overrun(overrun_b), .dbg_state(dbg_b)
  );

  // clock
  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // engine model for instance a: ack d cycles after the request rises
  initial resp_a = '0;
  always @(negedge clk_100MHz) begin
    if (req_a == '0) begin
      cnt_a = 0;
      resp_a = '0;
    end else begin
      cnt_a++;
      resp_a = '0;
      if (int'(phase_a) != stall_phase &&
          cnt_a == ((int'(phase_a) == slow_phase) ? slow_delay : 3))
        resp_a = req_a;
    end
  end

  // engine model for instance b: always acks after 2 cycles
  initial ack_b = '0;
  always @(negedge clk_100MHz) begin
    if (req_b == '0) begin
      cnt_b = 0;
      ack_b = '0;
    end else begin
      cnt_b++;
      ack_b = (cnt_b == 2) ? req_b : '0;
    end
  end

  // scoreboard / monitor for instance a
  always @(negedge clk_100MHz) begin
    if (req_a != '0) begin
      if (prev_a == '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_req: got unexpected upd_req=%b, required none", req_a);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (req_a !== e) begin
            bad++;
            $display("FAIL sb_req: got upd_req=%b, required %b", req_a, e);
          end
        end
        if (phase_a != 2'd0) begin
          total++;
          if (zero_run !== 1) begin
            bad++;
            $display("FAIL gap_len: got %0d idle cycles before phase %0d, required 1", zero_run, phase_a);
          end
        end
        zero_run = 0;
        cur_len = 1;
      end else begin
        cur_len++;
      end
      hi_len[phase_a] = cur_len;
    end else begin
      zero_run++;
    end
    prev_a = req_a;
    if (done_a) done_cnt_a++;
  end

  always @(negedge clk_100MHz) begin
    if (req_b != '0 && prev_b == '0 && phase_b == 2'd0) seq_b++;
    prev_b = req_b;
    if (done_b) done_cnt_b++;
  end

  // driver tasks
  task automatic blank_entry();
    @(negedge clk_100MHz);
    y = 10'd479;
    @(negedge clk_100MHz);
    y = 10'd480;
    exp_fc++;
    @(negedge clk_100MHz);
  endtask

  task automatic push_seq();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    total++;
    if (busy_a || busy_b) begin
      bad++;
      $display("FAIL wait_idle: busy still high after %0d cycles, required low", budget);
    end
    @(negedge clk_100MHz);
    y = 10'd0;
    @(negedge clk_100MHz);
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget);
    int n;
    n = 0;
    while (!(phase_a == p && req_a != '0) && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    total++;
    if (!(phase_a == p && req_a != '0)) begin
      bad++;
      $display("FAIL wait_phase: phase %0d never requested, phase_idx=%0d upd_req=%b", p, phase_a, req_a);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk_100MHz);
    clr_err = 1'b1;
    @(negedge clk_100MHz);
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    y = 10'd0;
    exp_fc = 0;
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
    @(negedge clk_100MHz);
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    total += 6;
    if (req_a !== 4'b0)  begin bad++; $display("FAIL rst_req: got %b, required 0000", req_a); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy_a); end
    if (fcnt_a !== 16'd0) begin bad++; $display("FAIL rst_fcnt: got %0d, required 0", fcnt_a); end
    if ({timeout_a, overrun_a, done_a} !== 3'b000) begin
      bad++; $display("FAIL rst_flags: got %b, required 000", {timeout_a, overrun_a, done_a});
    end
    if ({phase_a, err_phase_a} !== 4'b0) begin
      bad++; $display("FAIL rst_idx: got %b, required 0000", {phase_a, err_phase_a});
    end
    if (dbg_a !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d, required 0", dbg_a); end
    do_reset();
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt_a;
    push_seq();
    blank_entry();
    total++;
    if (req_a !== 4'b0001) begin bad++; $display("FAIL first_req: got %b, required 0001", req_a); end
    wait_idle(200);
    total += 7;
    if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt_a - d0); end
    if (fcnt_a !== 16'(exp_fc)) begin bad++; $display("FAIL basic_fcnt: got %0d, required %0d", fcnt_a, exp_fc); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b, required 0", busy_a); end
    if (timeout_a !== 1'b0) begin bad++; $display("FAIL basic_to: got %b, required 0", timeout_a); end
    for (int i = 0; i < 3; i++)
      if (hi_len[i] !== 3) begin bad++; $display("FAIL basic_len: phase %0d high %0d cycles, required 3", i, hi_len[i]); end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_cnt_a;
    stall_phase = 2;
    push_seq();
    blank_entry();
    wait_idle(200);
    stall_phase = -1;
    total += 5;
    if (hi_len[2] !== 16) begin bad++; $display("FAIL to_len: got %0d cycles, required 16", hi_len[2]); end
    if (timeout_a !== 1'b1) begin bad++; $display("FAIL to_flag: got %b, required 1", timeout_a); end
    if (err_phase_a !== 2'd2) begin bad++; $display("FAIL to_phase: got %0d, required 2", err_phase_a); end
    if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL to_done: got %0d pulses, required 1", done_cnt_a - d0); end
    if (hi_len[3] !== 3) begin bad++; $display("FAIL to_next: phase 3 high %0d cycles, required 3", hi_len[3]); end
    pulse_clr();
    total += 2;
    if (timeout_a !== 1'b0) begin bad++; $display("FAIL to_clr: got %b, required 0", timeout_a); end
    if (err_phase_a !== 2'd2) begin bad++; $display("FAIL to_keep: got %0d, required 2", err_phase_a); end
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt_a;
    slow_phase = 1;
    slow_delay = 12;
    push_seq();
    blank_entry();
    wait_phase(2'd1, 50);
    y = 10'd0;
    @(negedge clk_100MHz);
    total += 2;
    if (overrun_a !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b, required 1", overrun_a); end
    if (busy_a !== 1'b1) begin bad++; $display("FAIL ovr_busy: got %b, required 1", busy_a); end
    wait_idle(200);
    slow_phase = -1;
    total += 4;
    if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL ovr_done: got %0d pulses, required 1", done_cnt_a - d0); end
    if (hi_len[1] !== 12) begin bad++; $display("FAIL ovr_len: got %0d cycles, required 12", hi_len[1]); end
    if (timeout_a !== 1'b0) begin bad++; $display("FAIL ovr_to: got %b, required 0", timeout_a); end
    if (overrun_a !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b, required 1", overrun_a); end
    pulse_clr();
    total++;
    if (overrun_a !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b, required 0", overrun_a); end
  endtask

  task automatic test_enable();
    int d0;
    d0 = done_cnt_a;
    enable = 1'b0;
    blank_entry();
    wait_idle(50);
    blank_entry();
    wait_idle(50);
    total += 2;
    if (fcnt_a !== 16'(exp_fc)) begin bad++; $display("FAIL en_fcnt: got %0d, required %0d", fcnt_a, exp_fc); end
    if (done_cnt_a - d0 !== 0) begin bad++; $display("FAIL en_done: got %0d pulses, required 0", done_cnt_a - d0); end
    enable = 1'b1;
    push_seq();
    blank_entry();
    wait_phase(2'd1, 50);
    enable = 1'b0;
    wait_idle(200);
    enable = 1'b1;
    total += 2;
    if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL en_mid: got %0d pulses, required 1", done_cnt_a - d0); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL en_left: %0d requests missing, required 0", exp_q.size()); end
  endtask

  task automatic test_spurious();
    slow_phase = 0;
    slow_delay = 8;
    push_seq();
    blank_entry();
    @(negedge clk_100MHz);
    spur_a = 4'b1000;
    @(negedge clk_100MHz);
    spur_a = 4'b0000;
    total += 2;
    if (req_a !== 4'b0001) begin bad++; $display("FAIL spur_req: got %b, required 0001", req_a); end
    if (phase_a !== 2'd0) begin bad++; $display("FAIL spur_phase: got %0d, required 0", phase_a); end
    wait_idle(200);
    slow_phase = -1;
    total++;
    if (hi_len[0] !== 8) begin bad++; $display("FAIL spur_len: got %0d cycles, required 8", hi_len[0]); end
  endtask

  task automatic test_reset_mid();
    slow_phase = 1;
    slow_delay = 12;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    blank_entry();
    wait_phase(2'd1, 50);
    #2;
    reset_n = 1'b0;
    #1;
    total += 3;
    if (req_a !== 4'b0) begin bad++; $display("FAIL rmid_req: got %b, required 0000", req_a); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b, required 0", busy_a); end
    if (fcnt_a !== 16'd0) begin bad++; $display("FAIL rmid_fcnt: got %0d, required 0", fcnt_a); end
    slow_phase = -1;
    do_reset();
  endtask

  task automatic test_frame_div();
    do_reset();
    seq_b = 0;
    done_cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      push_seq();
      blank_entry();
      wait_idle(200);
      total++;
      if (seq_b !== (i / 3) + 1) begin
        bad++; $display("FAIL div_seq: after entry %0d got %0d sequences, required %0d", i + 1, seq_b, (i / 3) + 1);
      end
    end
    total += 3;
    if (done_cnt_b !== 2) begin bad++; $display("FAIL div_done: got %0d pulses, required 2", done_cnt_b); end
    if (fcnt_b !== 16'd6) begin bad++; $display("FAIL div_fcnt: got %0d, required 6", fcnt_b); end
    if (fcnt_a !== 16'(exp_fc)) begin bad++; $display("FAIL div_fcnt_a: got %0d, required %0d", fcnt_a, exp_fc); end
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b1;
    y = 10'd0;
    clr_err = 1'b0;
    spur_a = '0;
    for (int i = 0; i < 4; i++) hi_len[i] = 0;
    test_reset();
    test_basic();
    test_timeout();
    test_overrun();
    test_enable();
    test_spurious();
    test_reset_mid();
    test_frame_div();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expected requests never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
